// File: rtl/potato_pkg.sv
// Shared types and constants for the potato countdown-timer controller.
package potato_pkg;

  typedef enum logic [1:0] {
    EDIT  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [4:0] m2;
    logic [4:0] m1;
    logic [4:0] s2;
    logic [4:0] s1;
  } bcd_time_t;

  localparam logic [4:0] SEL_S1   = 5'd0;
  localparam logic [4:0] SEL_S2   = 5'd1;
  localparam logic [4:0] SEL_M1   = 5'd2;
  localparam logic [4:0] SEL_M2   = 5'd3;
  localparam logic [4:0] SEL_BAR  = 5'd4;
  localparam logic [4:0] SEL_NONE = 5'd5;

  localparam logic [4:0] SEC_TENS_MAX = 5'd5;
  localparam logic [4:0] DIGIT_MAX    = 5'd9;

  // One edit step on a single digit, wrapping between 0 and max in both directions.
  function automatic logic [4:0] digit_step(input logic [4:0] d, input logic [4:0] max,
                                            input logic up);
    logic [4:0] r;
    if (up) r = (d >= max) ? 5'd0 : d + 5'd1;
    else    r = (d == 5'd0) ? max : d - 5'd1;
    return r;
  endfunction

endpackage

// File: rtl/potato_bcd_down.sv
// Combinational one-second decrement of an mm:ss BCD time, with a flag for a 00:00 result.
module potato_bcd_down
  import potato_pkg::*;
(
  input  bcd_time_t cur,
  output bcd_time_t dec,
  output logic      dec_zero
);

  always_comb begin
    dec = cur;
    if (cur.s1 != 5'd0) begin
      dec.s1 = cur.s1 - 5'd1;
    end else begin
      dec.s1 = DIGIT_MAX;
      if (cur.s2 != 5'd0) begin
        dec.s2 = cur.s2 - 5'd1;
      end else begin
        dec.s2 = SEC_TENS_MAX;
        if (cur.m1 != 5'd0) begin
          dec.m1 = cur.m1 - 5'd1;
        end else begin
          dec.m1 = DIGIT_MAX;
          dec.m2 = cur.m2 - 5'd1;
        end
      end
    end
  end

  assign dec_zero = (dec == '0);

endmodule

// File: rtl/potato_timer_ctrl.sv
// Edit/run/pause/expiry controller for the potato mm:ss countdown display.
// Optional cursor/bar blinking is enabled by defining POTATO_BLINK_EN.
module potato_timer_ctrl
  import potato_pkg::*;
#(
  parameter int TICK_DIV  = 100_000_000,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_next,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_start,
  output logic [4:0] second1,
  output logic [4:0] second2,
  output logic [4:0] minute1,
  output logic [4:0] minute2,
  output logic [4:0] select,
  output logic       running,
  output logic       expired
);

  // Prescaler and blink counter share one width so both divisors stay in use.
  localparam int CNT_W = $clog2((TICK_DIV > BLINK_DIV) ? TICK_DIV : BLINK_DIV);
  localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(TICK_DIV - 1);

  state_t           state_reg;
  bcd_time_t        time_reg;
  bcd_time_t        preset_reg;
  bcd_time_t        time_dec;
  logic             dec_zero;
  logic [2:0]       cursor_reg;
  logic [CNT_W-1:0] presc_reg;
  logic [4:0]       select_reg;
  logic             running_reg;
  logic             expired_reg;

  logic       do_next, do_up, do_down, any_btn;
  logic       tick, time_zero, blink_mask;
  logic [2:0] cursor_adv, cursor_sel;

  assign do_next = !btn_start && btn_next;
  assign do_up   = !btn_start && !btn_next && btn_up;
  assign do_down = !btn_start && !btn_next && !btn_up && btn_down;
  assign any_btn = btn_start || btn_next || btn_up || btn_down;

  assign tick       = (presc_reg == PRESC_LAST);
  assign time_zero  = (time_reg == '0);
  assign cursor_adv = (cursor_reg == 3'd4) ? 3'd0 : cursor_reg + 3'd1;
  assign cursor_sel = do_next ? cursor_adv : cursor_reg;

  potato_bcd_down u_bcd_down (
    .cur      (time_reg),
    .dec      (time_dec),
    .dec_zero (dec_zero)
  );

`ifdef POTATO_BLINK_EN
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_DIV - 1);

  logic [CNT_W-1:0] blink_cnt_reg;
  logic             blink_off_reg;
  logic             blink_run;

  // Any button restarts the phase so the cursor is visible right after an edit.
  assign blink_run  = ((state_reg == EDIT) || (state_reg == DONE)) && !any_btn;
  assign blink_mask = blink_run && ((blink_cnt_reg == BLINK_LAST) ? !blink_off_reg
                                                                  : blink_off_reg);

  always_ff @(posedge clk) begin
    if (rst || !blink_run) begin
      blink_cnt_reg <= '0;
      blink_off_reg <= 1'b0;
    end else if (blink_cnt_reg == BLINK_LAST) begin
      blink_cnt_reg <= '0;
      blink_off_reg <= !blink_off_reg;
    end else begin
      blink_cnt_reg <= blink_cnt_reg + CNT_W'(1);
    end
  end
`else
  assign blink_mask = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= EDIT;
      time_reg    <= '0;
      preset_reg  <= '0;
      cursor_reg  <= 3'd0;
      presc_reg   <= '0;
      select_reg  <= SEL_S1;
      running_reg <= 1'b0;
      expired_reg <= 1'b0;
    end else begin
      case (state_reg)
        EDIT: begin
          select_reg <= blink_mask ? SEL_NONE : {2'b00, cursor_sel};
          if (btn_start) begin
            if (!time_zero) begin
              preset_reg  <= time_reg;
              presc_reg   <= '0;
              state_reg   <= RUN;
              running_reg <= 1'b1;
              select_reg  <= SEL_BAR;
            end
          end else begin
            if (do_next) cursor_reg <= cursor_adv;
            if (do_up || do_down) begin
              case (cursor_reg)
                3'd0:    time_reg.s1 <= digit_step(time_reg.s1, DIGIT_MAX, do_up);
                3'd1:    time_reg.s2 <= digit_step(time_reg.s2, SEC_TENS_MAX, do_up);
                3'd2:    time_reg.m1 <= digit_step(time_reg.m1, DIGIT_MAX, do_up);
                3'd3:    time_reg.m2 <= digit_step(time_reg.m2, DIGIT_MAX, do_up);
                default: ;
              endcase
            end
          end
        end
        RUN: begin
          // The pause edge still counts as a run cycle, so paused time adds exactly its length.
          if (tick) begin
            presc_reg <= '0;
            time_reg  <= time_dec;
          end else begin
            presc_reg <= presc_reg + CNT_W'(1);
          end
          if (tick && dec_zero) begin
            state_reg   <= DONE;
            running_reg <= 1'b0;
            expired_reg <= 1'b1;
            select_reg  <= SEL_BAR;
          end else if (btn_start) begin
            state_reg   <= PAUSE;
            running_reg <= 1'b0;
            select_reg  <= SEL_NONE;
          end
        end
        PAUSE: begin
          if (btn_start) begin
            state_reg   <= RUN;
            running_reg <= 1'b1;
            select_reg  <= SEL_BAR;
          end else if (btn_next) begin
            state_reg   <= EDIT;
            cursor_reg  <= 3'd0;
            select_reg  <= SEL_S1;
          end
        end
        DONE: begin
          if (any_btn) begin
            state_reg   <= EDIT;
            time_reg    <= preset_reg;
            cursor_reg  <= 3'd0;
            expired_reg <= 1'b0;
            select_reg  <= SEL_S1;
          end else begin
            select_reg  <= blink_mask ? SEL_NONE : SEL_BAR;
          end
        end
        default: state_reg <= EDIT;
      endcase
    end
  end

  assign second1 = time_reg.s1;
  assign second2 = time_reg.s2;
  assign minute1 = time_reg.m1;
  assign minute2 = time_reg.m2;
  assign select  = select_reg;
  assign running = running_reg;
  assign expired = expired_reg;

endmodule

// File: tb/tb_potato_timer_ctrl.sv
// Directed bench for potato_timer_ctrl with TICK_DIV = 4 and blinking disabled.
module tb_potato_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_next, btn_up, btn_down, btn_start;
  logic [4:0] second1, second2, minute1, minute2, select;
  logic       running, expired;

  int total = 0;
  int bad   = 0;

  potato_timer_ctrl #(.TICK_DIV(4), .BLINK_DIV(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_next  (btn_next),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_start (btn_start),
    .second1   (second1),
    .second2   (second2),
    .minute1   (minute1),
    .minute2   (minute2),
    .select    (select),
    .running   (running),
    .expired   (expired)
  );

  always #5 clk = ~clk;

  // Advance one clock and sample 1 ns after the edge.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Buttons encoded {start, next, up, down}; held for exactly one edge.
  task automatic press(input logic [3:0] b, input int n = 1);
    for (int i = 0; i < n; i++) begin
      {btn_start, btn_next, btn_up, btn_down} = b;
      step();
      {btn_start, btn_next, btn_up, btn_down} = 4'b0000;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] tm(input int m2, input int m1, input int s2, input int s1);
    return {12'd0, m2[4:0], m1[4:0], s2[4:0], s1[4:0]};
  endfunction

  function automatic logic [31:0] now_time();
    return {12'd0, minute2, minute1, second2, second1};
  endfunction

  localparam logic [3:0] B_START = 4'b1000;
  localparam logic [3:0] B_NEXT  = 4'b0100;
  localparam logic [3:0] B_UP    = 4'b0010;
  localparam logic [3:0] B_DOWN  = 4'b0001;

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    {btn_start, btn_next, btn_up, btn_down} = 4'b0000;
    do_reset();
    check("reset_time", now_time(), tm(0, 0, 0, 0));
    check("reset_select", 32'(select), 32'd0);
    check("reset_running", 32'(running), 32'd0);
    check("reset_expired", 32'(expired), 32'd0);

    // Scenario 1: edit and per-digit wrap
    press(B_UP, 6);
    check("s1_up6", 32'(second1), 32'd6);
    press(B_NEXT);
    check("sel_after_next", 32'(select), 32'd1);
    press(B_UP, 7);
    check("s2_up7_wrap", 32'(second2), 32'd1);
    press(B_DOWN);
    check("s2_down_to0", 32'(second2), 32'd0);
    press(B_DOWN);
    check("s2_down_wrap5", 32'(second2), 32'd5);
    press(B_NEXT, 3);
    check("sel_cursor4", 32'(select), 32'd4);
    press(B_UP);
    check("up_at_bar_ignored", now_time(), tm(0, 0, 5, 6));
    press(B_NEXT);
    check("cursor_wrap0", 32'(select), 32'd0);
    press(B_UP, 4);
    check("s1_up_wrap0", 32'(second1), 32'd0);
    press(B_DOWN);
    check("s1_down_wrap9", 32'(second1), 32'd9);

    // Scenario 4: start ignored at 00:00
    do_reset();
    press(B_START);
    check("zero_start_running", 32'(running), 32'd0);
    check("zero_start_select", 32'(select), 32'd0);

    // Scenario 2: 10:00 borrow chain through to expiry
    press(B_NEXT, 3);
    press(B_UP);
    check("preset_10_00", now_time(), tm(1, 0, 0, 0));
    press(B_START);
    check("run_running", 32'(running), 32'd1);
    check("run_select", 32'(select), 32'd4);
    step(3);
    check("no_dec_before_tick", now_time(), tm(1, 0, 0, 0));
    step();
    check("first_dec_09_59", now_time(), tm(0, 9, 5, 9));
    step(2395);
    check("at_00_01", now_time(), tm(0, 0, 0, 1));
    check("not_yet_expired", 32'(expired), 32'd0);
    step();
    check("final_00_00", now_time(), tm(0, 0, 0, 0));
    check("expired_same_edge", 32'(expired), 32'd1);
    check("done_running", 32'(running), 32'd0);
    check("done_select", 32'(select), 32'd4);
    press(B_NEXT);
    check("done_reload", now_time(), tm(1, 0, 0, 0));
    check("done_reload_sel", 32'(select), 32'd0);
    check("done_reload_exp", 32'(expired), 32'd0);

    // Scenario 3: pause delays the next decrement by the paused cycles
    do_reset();
    press(B_UP, 5);
    press(B_START);
    step();
    press(B_START);
    check("pause_select", 32'(select), 32'd5);
    check("pause_running", 32'(running), 32'd0);
    step(9);
    press(B_START);
    check("resume_running", 32'(running), 32'd1);
    step();
    check("resume_no_dec_yet", now_time(), tm(0, 0, 0, 5));
    step();
    check("resume_dec_00_04", now_time(), tm(0, 0, 0, 4));
    press(B_START);
    press(B_NEXT);
    check("pause_to_edit_sel", 32'(select), 32'd0);
    check("pause_to_edit_time", now_time(), tm(0, 0, 0, 4));

    // Scenario 5: priority and DONE reload
    do_reset();
    press(B_UP);
    press(B_START | B_UP);
    check("prio_running", 32'(running), 32'd1);
    check("prio_digit", 32'(second1), 32'd1);
    step(4);
    check("prio_expired", 32'(expired), 32'd1);
    press(B_DOWN);
    check("reload_00_01", now_time(), tm(0, 0, 0, 1));
    check("reload_sel", 32'(select), 32'd0);
    press(B_START);
    step(3);
    press(B_START);
    check("start_on_final_expired", 32'(expired), 32'd1);
    check("start_on_final_running", 32'(running), 32'd0);

    // Scenario 6: reset mid-run
    do_reset();
    press(B_UP, 7);
    press(B_NEXT);
    press(B_UP, 2);
    press(B_NEXT);
    press(B_UP, 3);
    check("set_03_27", now_time(), tm(0, 3, 2, 7));
    press(B_START);
    step(2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_time", now_time(), tm(0, 0, 0, 0));
    check("rst_select", 32'(select), 32'd0);
    check("rst_running", 32'(running), 32'd0);
    press(B_START);
    check("preset_lost", 32'(running), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
